// File: rtl/truth_table_sweeper.sv
// Purpose: sweep all 2^N_IN input vectors into N_CH implementations and compare each enabled channel to channel 0.
// Latency: vector i sampled HOLD_CYC*(i+1) cycles after start; done pulses in the cycle after the last sample edge.
// Backpressure: none; start is taken only in IDLE, abort only in RUN, results held until the next start.
module truth_table_sweeper #(
    parameter int N_IN     = 3,
    parameter int N_CH     = 3,
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [N_CH-1:0]   ch_y,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     mismatch_cnt,
    output logic              first_bad_valid,
    output logic [N_IN-1:0]   first_bad_vec,
    output logic [N_CH-1:0]   first_bad_mask
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;
    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
    localparam logic [N_IN:0]   CNT_ONE   = (N_IN + 1)'(1);
    localparam logic [N_CH-1:0] GOLD_BIT  = N_CH'(1);

    state_t            state, state_n;
    logic [7:0]        hold_cnt, hold_n;
    logic [N_CH-1:0]   mask_q, mask_n;
    logic [N_CH-1:0]   diff;
    logic [N_IN-1:0]   vec_n, fbvec_n;
    logic              busy_n, done_n, pass_n, fbv_n;
    logic [N_IN:0]     cnt_n;
    logic [N_CH-1:0]   fbmask_n;

    // State and result registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            hold_cnt        <= '0;
            mask_q          <= '0;
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            mismatch_cnt    <= '0;
            first_bad_valid <= 1'b0;
            first_bad_vec   <= '0;
            first_bad_mask  <= '0;
        end else begin
            state           <= state_n;
            hold_cnt        <= hold_n;
            mask_q          <= mask_n;
            vec_out         <= vec_n;
            busy            <= busy_n;
            done            <= done_n;
            pass            <= pass_n;
            mismatch_cnt    <= cnt_n;
            first_bad_valid <= fbv_n;
            first_bad_vec   <= fbvec_n;
            first_bad_mask  <= fbmask_n;
        end
    end

    // Next-state and next-result logic; a vector is compared only on the last cycle of its hold window.
    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        mask_n   = mask_q;
        vec_n    = vec_out;
        busy_n   = busy;
        done_n   = 1'b0;
        pass_n   = pass;
        cnt_n    = mismatch_cnt;
        fbv_n    = first_bad_valid;
        fbvec_n  = first_bad_vec;
        fbmask_n = first_bad_mask;
        diff     = (ch_y ^ {N_CH{ch_y[0]}}) & mask_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_RUN;
                    mask_n   = ch_en | GOLD_BIT;
                    vec_n    = '0;
                    hold_n   = '0;
                    busy_n   = 1'b1;
                    pass_n   = 1'b0;
                    cnt_n    = '0;
                    fbv_n    = 1'b0;
                    fbvec_n  = '0;
                    fbmask_n = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Partial results stay visible; the pending comparison is dropped.
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                    hold_n  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    hold_n = '0;
                    if (diff != '0) begin
                        cnt_n = mismatch_cnt + CNT_ONE;
                        if (!first_bad_valid) begin
                            fbv_n    = 1'b1;
                            fbvec_n  = vec_out;
                            fbmask_n = diff;
                        end
                    end
                    if (vec_out == VEC_LAST) begin
                        state_n = S_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (cnt_n == '0);
                    end else begin
                        vec_n = vec_out + VEC_ONE;
                    end
                end else begin
                    hold_n = hold_cnt + 8'd1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: check the sweeper against Y = A&B | ~C channels with injectable faults, for HOLD_CYC 1 and 3.
// Latency: expected results queued at start, compared when done (or abort) is observed.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_truth_table_sweeper;

    typedef struct {
        bit         sel;     // 0: HOLD_CYC=1 instance, 1: HOLD_CYC=3 instance
        logic [2:0] en;
        logic [2:0] fch;     // channels inverted at faulty vectors
        logic [7:0] fvec;    // which vectors are faulty
        int         cnt;
        int         pass;
        int         fbv;
        int         fbvec;
        int         mask;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sel = 1'b0;
    logic [2:0] ch_en = 3'b000;
    logic [2:0] fch = 3'b000;
    logic [7:0] fvec = 8'h00;

    logic [2:0] ch_y1, ch_y3, vec1, vec3, fbvec1, fbvec3, mask1, mask3;
    logic       busy1, busy3, done1, done3, pass1, pass3, fbv1, fbv3;
    logic [3:0] cnt1, cnt3;

    logic [2:0] vec_m, fbvec_m, mask_m;
    logic       busy_m, done_m, pass_m, fbv_m;
    logic [3:0] cnt_m;

    int   checks = 0;
    int   errors = 0;
    rec_t tbl [8];
    rec_t sb [$];

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .N_CH(3), .HOLD_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort & ~sel),
        .ch_en(ch_en), .ch_y(ch_y1), .vec_out(vec1), .busy(busy1), .done(done1),
        .pass(pass1), .mismatch_cnt(cnt1), .first_bad_valid(fbv1),
        .first_bad_vec(fbvec1), .first_bad_mask(mask1)
    );

    truth_table_sweeper #(.N_IN(3), .N_CH(3), .HOLD_CYC(3)) dut3 (
        .clk(clk), .reset(reset), .start(start & sel), .abort(abort & sel),
        .ch_en(ch_en), .ch_y(ch_y3), .vec_out(vec3), .busy(busy3), .done(done3),
        .pass(pass3), .mismatch_cnt(cnt3), .first_bad_valid(fbv3),
        .first_bad_vec(fbvec3), .first_bad_mask(mask3)
    );

    // Channel models: golden function with selected channels inverted on faulty vectors.
    function automatic logic [2:0] model_y(input logic [2:0] v, input logic [2:0] fc,
                                           input logic [7:0] fv);
        logic f;
        f = (v[2] & v[1]) | ~v[0];
        return {3{f}} ^ (fc & {3{fv[v]}});
    endfunction

    always_comb ch_y1 = model_y(vec1, fch, fvec);
    always_comb ch_y3 = model_y(vec3, fch, fvec);

    assign vec_m   = sel ? vec3   : vec1;
    assign busy_m  = sel ? busy3  : busy1;
    assign done_m  = sel ? done3  : done1;
    assign pass_m  = sel ? pass3  : pass1;
    assign cnt_m   = sel ? cnt3   : cnt1;
    assign fbv_m   = sel ? fbv3   : fbv1;
    assign fbvec_m = sel ? fbvec3 : fbvec1;
    assign mask_m  = sel ? mask3  : mask1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_results(input string tag);
        rec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_cnt"},   int'(cnt_m),   e.cnt);
        chk({tag, "_pass"},  int'(pass_m),  e.pass);
        chk({tag, "_fbv"},   int'(fbv_m),   e.fbv);
        chk({tag, "_fbvec"}, int'(fbvec_m), e.fbvec);
        chk({tag, "_mask"},  int'(mask_m),  e.mask);
    endtask

    // Full sweep: optionally hold start high for extra cycles inside RUN to show it is ignored.
    task automatic run_sweep(input rec_t r, input int extra_start, input string tag);
        int cyc;
        int hc;
        sel   = r.sel;
        ch_en = r.en;
        fch   = r.fch;
        fvec  = r.fvec;
        hc    = r.sel ? 3 : 1;
        sb.push_back(r);
        cyc1();
        start = 1'b1;
        cyc1();                                  // edge E0 just passed
        if (extra_start == 0) start = 1'b0;
        chk({tag, "_busy0"}, int'(busy_m), 1);
        chk({tag, "_vec0"},  int'(vec_m), 0);
        chk({tag, "_clr"},   int'({cnt_m, fbv_m, pass_m}), 0);
        cyc = 0;
        while (!done_m && cyc < 100) begin
            cyc1();
            cyc++;
            if (cyc >= extra_start) start = 1'b0;
            if (!done_m) chk({tag, "_vec"}, int'(vec_m), cyc / hc);
        end
        chk({tag, "_latency"}, cyc, 8 * hc);
        chk({tag, "_done_busy"}, int'(busy_m), 0);
        chk({tag, "_vec_end"}, int'(vec_m), 7);
        compare_results(tag);
        cyc1();
        chk({tag, "_done_pulse"}, int'({done_m, busy_m}), 0);
        chk({tag, "_hold_cnt"}, int'(cnt_m), r.cnt);
    endtask

    initial begin : main
        rec_t ab;
        int   cyc;
        tbl[0] = '{0, 3'b111, 3'b000, 8'h00, 0, 1, 0, 0, 0};
        tbl[1] = '{0, 3'b111, 3'b100, 8'h48, 2, 0, 1, 3, 4};
        tbl[2] = '{0, 3'b011, 3'b100, 8'h48, 0, 1, 0, 0, 0};
        tbl[3] = '{0, 3'b110, 3'b010, 8'h48, 2, 0, 1, 3, 2};
        tbl[4] = '{0, 3'b111, 3'b110, 8'h48, 2, 0, 1, 3, 6};
        tbl[5] = '{0, 3'b111, 3'b100, 8'hFF, 8, 0, 1, 0, 4};
        tbl[6] = '{1, 3'b111, 3'b000, 8'h00, 0, 1, 0, 0, 0};
        tbl[7] = '{1, 3'b101, 3'b100, 8'h48, 2, 0, 1, 3, 4};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec",  int'(vec1), 0);
        chk("rst_flags", int'({busy1, done1, pass1, fbv1}), 0);
        chk("rst_cnt",  int'(cnt1), 0);
        chk("rst_fb",   int'({fbvec1, mask1}), 0);
        chk("rst_vec3", int'(vec3), 0);
        reset = 1'b0;

        // abort is ignored in IDLE
        abort = 1'b1;
        cyc1();
        cyc1();
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy1), 0);

        for (int i = 0; i < 8; i++) run_sweep(tbl[i], 0, $sformatf("vec%0d", i));

        // Abort at vec_out=4; vector 4 is also faulty, so its dropped comparison must not count.
        sel = 1'b0; ch_en = 3'b111; fch = 3'b100; fvec = 8'h58;
        ab = '{0, 3'b111, 3'b100, 8'h58, 1, 0, 1, 3, 4};
        sb.push_back(ab);
        cyc1();
        start = 1'b1;
        cyc1();
        start = 1'b0;
        cyc = 0;
        while (vec_m != 3'd4 && cyc < 50) begin
            cyc1();
            cyc++;
        end
        chk("abort_reach", cyc, 4);
        abort = 1'b1;
        cyc1();
        abort = 1'b0;
        chk("abort_busy", int'(busy_m), 0);
        chk("abort_done", int'(done_m), 0);
        compare_results("abort");
        for (int k = 0; k < 4; k++) begin
            cyc1();
            chk("abort_no_done", int'({done_m, busy_m}), 0);
        end
        run_sweep(tbl[0], 0, "post_abort");

        // Reset mid-sweep at vec_out=5
        sel = 1'b0; ch_en = 3'b111; fch = 3'b100; fvec = 8'h48;
        cyc1();
        start = 1'b1;
        cyc1();
        start = 1'b0;
        cyc = 0;
        while (vec_m != 3'd5 && cyc < 50) begin
            cyc1();
            cyc++;
        end
        chk("rst_reach", cyc, 5);
        reset = 1'b1;
        #2;
        chk("midrst_vec",   int'(vec1), 0);
        chk("midrst_flags", int'({busy1, done1, pass1, fbv1}), 0);
        chk("midrst_res",   int'({cnt1, fbvec1, mask1}), 0);
        cyc1();
        reset = 1'b0;
        cyc1();
        chk("midrst_no_done", int'({done1, busy1}), 0);

        // start held high into RUN does not restart or lengthen the sweep
        run_sweep(tbl[1], 3, "start_in_run");

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
